scs8hd_xnor3_paracc_1: RTL and testbench

SCS8HD_XNOR3_PARACC_1 -- requirements
Module: scs8hd_xnor3_paracc_1

---
 rtl/scs8hd_xnor3_paracc_1.sv | 99 +++++++++
 tb/tb_scs8hd_xnor3_paracc_1.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/scs8hd_xnor3_paracc_1.sv
// Frame parity accumulator over xnor3 triplets with a one-cycle HOLD result phase.
// Optional triplet-count output CNT is enabled by defining SCS8HD_PARACC_CNT_EN.
module scs8hd_xnor3_paracc_1 #(
  parameter int MAXLEN = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       VALID,
  input  logic       LAST,
  input  logic       EXP,
  output logic       READY,
  output logic       X,
  output logic       DONE,
  output logic       ERR
`ifdef SCS8HD_PARACC_CNT_EN
  ,
  output logic [7:0] CNT
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, HOLD = 2'd2} state_e;

  state_e     state_q, state_d;
  logic       acc_q, acc_d;
  logic [7:0] len_q, len_d;
  logic       ovf_q, ovf_d;
  logic       x_q, x_d;
  logic       err_q, err_d;
  logic       t, close;

  assign t = ~(A ^ B ^ C);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      len_q   <= 8'd0;
      ovf_q   <= 1'b0;
      x_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      x_q     <= x_d;
      err_q   <= err_d;
    end
  end

  // Result registers load on the closing edge so they are valid throughout HOLD.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    close   = 1'b0;
    case (state_q)
      IDLE: if (VALID) begin
        acc_d   = t;
        len_d   = 8'd1;
        ovf_d   = 1'b0;
        close   = LAST;
        state_d = LAST ? HOLD : ACC;
      end
      ACC: if (VALID) begin
        acc_d   = acc_q ^ t;
        len_d   = len_q + 8'd1;
        close   = LAST || (len_d == 8'(MAXLEN));
        ovf_d   = close && !LAST;
        state_d = close ? HOLD : ACC;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    x_d   = close ? acc_d : x_q;
    err_d = close ? ((acc_d != EXP) || ovf_d) : err_q;
  end

  always_comb begin
    READY = !RESET && (state_q != HOLD);
    DONE  = (state_q == HOLD);
    X     = x_q;
    ERR   = err_q;
  end

`ifdef SCS8HD_PARACC_CNT_EN
  logic [7:0] cnt_q;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)      cnt_q <= 8'd0;
    else if (close) cnt_q <= len_d;
  end
  assign CNT = cnt_q;
`endif

endmodule

// File: tb/tb_scs8hd_xnor3_paracc_1.sv
// Directed + random bench for scs8hd_xnor3_paracc_1 against a frame-level parity model.
module tb_scs8hd_xnor3_paracc_1;
  localparam int MAXLEN = 4;

  logic CLK = 1'b0, RESET = 1'b1;
  logic A = 0, B = 0, C = 0, VALID = 0, LAST = 0, EXP = 0;
  logic READY, X, DONE, ERR;
`ifdef SCS8HD_PARACC_CNT_EN
  logic [7:0] CNT;
`endif

  scs8hd_xnor3_paracc_1 #(.MAXLEN(MAXLEN)) dut (
    .CLK(CLK), .RESET(RESET), .A(A), .B(B), .C(C), .VALID(VALID), .LAST(LAST), .EXP(EXP),
    .READY(READY), .X(X), .DONE(DONE), .ERR(ERR)
`ifdef SCS8HD_PARACC_CNT_EN
    , .CNT(CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;

  // Frame-level model: triplet values of the open frame plus last reported result.
  bit   fq[$];
  bit   m_hold = 0, m_x = 0, m_err = 0;
  int   m_cnt = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".done"},  {7'd0, DONE},  {7'd0, m_hold});
    chk({tag, ".ready"}, {7'd0, READY}, {7'd0, !m_hold});
    chk({tag, ".x"},     {7'd0, X},     {7'd0, m_x});
    chk({tag, ".err"},   {7'd0, ERR},   {7'd0, m_err});
`ifdef SCS8HD_PARACC_CNT_EN
    chk({tag, ".cnt"},   CNT,           8'(m_cnt));
`endif
  endtask

  task automatic model_reset();
    fq.delete();
    m_hold = 0; m_x = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic step(input string tag, input bit v, a, b, c, l, e);
    bit par;
    @(negedge CLK);
    VALID = v; A = a; B = b; C = c; LAST = l; EXP = e;
    chk({tag, ".ready_pre"}, {7'd0, READY}, {7'd0, !m_hold});
    @(posedge CLK);
    if (m_hold) m_hold = 0;
    else if (v) begin
      fq.push_back(!(a ^ b ^ c));
      if (l || fq.size() == MAXLEN) begin
        par = 0;
        foreach (fq[i]) par ^= fq[i];
        m_x = par; m_err = (par != e) || !l; m_cnt = fq.size();
        m_hold = 1;
        fq.delete();
      end
    end
    #1;
    chk_outs(tag);
  endtask

  initial begin
    #2;
    chk("rst.ready", {7'd0, READY}, 8'd0);
    chk("rst.done",  {7'd0, DONE},  8'd0);
    chk("rst.x",     {7'd0, X},     8'd0);
    chk("rst.err",   {7'd0, ERR},   8'd0);
    @(negedge CLK); @(negedge CLK);
    RESET = 0;
    #1 chk("rel.x_hold", {7'd0, X}, 8'd0);
    @(posedge CLK); #1;
    chk("rel.ready", {7'd0, READY}, 8'd1);

    // single triplet frame
    step("s1", 1, 1, 0, 0, 1, 0);
    chk("s1.done_c", {7'd0, DONE}, 8'd1);
    chk("s1.x_c",    {7'd0, X},    8'd0);
    chk("s1.err_c",  {7'd0, ERR},  8'd0);
    step("s1h", 0, 0, 0, 0, 0, 0);

    // three-triplet frame, t = 1,1,0
    step("f3a", 1, 0, 0, 0, 0, 0);
    step("f3b", 1, 1, 1, 0, 0, 0);
    step("f3c", 1, 1, 1, 1, 1, 1);
    chk("f3.x_c",   {7'd0, X},   8'd0);
    chk("f3.err_c", {7'd0, ERR}, 8'd1);
`ifdef SCS8HD_PARACC_CNT_EN
    chk("f3.cnt_c", CNT, 8'd3);
`endif
    // VALID offered during HOLD must be ignored
    step("f3h", 1, 0, 0, 0, 1, 1);

    // overflow at MAXLEN, then a fresh single-triplet frame
    step("ov1", 1, 0, 0, 0, 0, 1);
    step("ov2", 1, 0, 0, 1, 0, 1);
    step("ov3", 1, 1, 1, 0, 0, 1);
    step("ov4", 1, 0, 1, 1, 0, 1);
    chk("ov.done_c", {7'd0, DONE}, 8'd1);
    chk("ov.err_c",  {7'd0, ERR},  8'd1);
    step("ovh", 0, 0, 0, 0, 0, 0);
    step("ov5", 1, 0, 0, 0, 1, 1);
`ifdef SCS8HD_PARACC_CNT_EN
    chk("ov5.cnt_c", CNT, 8'd1);
`endif
    step("ov5h", 0, 0, 0, 0, 0, 0);

    // gaps: inputs toggle while VALID=0
    step("g1", 1, 1, 0, 0, 0, 0);
    step("g2", 0, 1, 1, 1, 1, 1);
    step("g3", 0, 0, 1, 0, 1, 0);
    step("g4", 1, 0, 0, 0, 1, 0);
    chk("g.x_c", {7'd0, X}, 8'd1);
    step("g4h", 0, 0, 0, 0, 0, 0);

    // async reset mid-frame
    step("r1", 1, 1, 0, 0, 0, 0);
    step("r2", 1, 0, 0, 0, 0, 0);
    @(posedge CLK); #3;
    RESET = 1;
    #1;
    model_reset();
    chk("ar.ready", {7'd0, READY}, 8'd0);
    chk("ar.done",  {7'd0, DONE},  8'd0);
    chk("ar.x",     {7'd0, X},     8'd0);
    chk("ar.err",   {7'd0, ERR},   8'd0);
`ifdef SCS8HD_PARACC_CNT_EN
    chk("ar.cnt", CNT, 8'd0);
`endif
    @(negedge CLK); VALID = 0;
    RESET = 0;
    step("ar.fresh", 1, 1, 1, 1, 1, 0);
    chk("ar.x_c", {7'd0, X}, 8'd0);
    step("ar.h", 0, 0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom % 4) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom % 4) == 0, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
